// File: rtl/snake_dir_pkg.sv
// rtl/snake_dir_pkg.sv - direction codes and helper functions shared by the snake direction controller
package snake_dir_pkg;

   localparam int DIR_W = 3;

   localparam logic [DIR_W-1:0] DIR_LEFT  = 3'b001;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 3'b010;
   localparam logic [DIR_W-1:0] DIR_UP    = 3'b011;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 3'b100;

   // Heading that would make the snake run back into itself; 000 for non-direction codes
   function automatic logic [DIR_W-1:0] dir_opposite(input logic [DIR_W-1:0] code);
      case (code)
         DIR_LEFT:  return DIR_RIGHT;
         DIR_RIGHT: return DIR_LEFT;
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         default:   return 3'b000;
      endcase
   endfunction

   function automatic logic dir_valid(input logic [DIR_W-1:0] code);
      return (code == DIR_LEFT) || (code == DIR_RIGHT) ||
             (code == DIR_UP)   || (code == DIR_DOWN);
   endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// rtl/snake_dir_ctrl_if.sv - button pins, game tick and per-player heading outputs
interface snake_dir_ctrl_if #(
   parameter int NUM_PLAYERS = 2
);
   import snake_dir_pkg::*;

   logic [NUM_PLAYERS-1:0]       btn_l;
   logic [NUM_PLAYERS-1:0]       btn_r;
   logic [NUM_PLAYERS-1:0]       btn_u;
   logic [NUM_PLAYERS-1:0]       btn_d;
   logic                         tick;
   logic [DIR_W*NUM_PLAYERS-1:0] direction;
   logic [NUM_PLAYERS-1:0]       dir_changed;
   logic [NUM_PLAYERS-1:0]       turn_drop;

   // Board / game side: drives pins and tick, consumes headings
   modport master (
      output btn_l, btn_r, btn_u, btn_d, tick,
      input  direction, dir_changed, turn_drop
   );

   // Controller side
   modport slave (
      input  btn_l, btn_r, btn_u, btn_d, tick,
      output direction, dir_changed, turn_drop
   );

endinterface

// File: rtl/dir_btn_debounce.sv
// rtl/dir_btn_debounce.sv - one button: 2-flop sync, optional debounce (DIR_CTRL_DEBOUNCE_EN), press edge detect
module dir_btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   logic sync1;
   logic s;
   logic b;
   logic b_prev;

   // Two-flop synchroniser for the raw asynchronous pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         sync1 <= btn;
         s     <= sync1;
      end
   end

`ifdef DIR_CTRL_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // b follows s only after s has disagreed with it for DEB_CYCLES cycles in a row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         b   <= 1'b0;
      end else if (s == b) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
         cnt <= '0;
         b   <= s;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   logic deb_unused;

   assign deb_unused = (DEB_CYCLES > 0);
   assign b          = s;
`endif

   // Previous debounced level for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_prev <= 1'b0;
      end else begin
         b_prev <= b;
      end
   end

   assign press = b & ~b_prev;

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - per-player turn filter, pending-turn queue and tick-driven heading update (debounce: DIR_CTRL_DEBOUNCE_EN)
module snake_dir_ctrl
   import snake_dir_pkg::*;
#(
   parameter int               NUM_PLAYERS = 2,
   parameter int               QDEPTH      = 2,
   parameter int               DEB_CYCLES  = 16,
   parameter logic [DIR_W-1:0] INIT_DIR    = 3'b010
) (
   input  logic            clk,
   input  logic            rst_n,
   snake_dir_ctrl_if.slave bus
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   logic [DIR_W*NUM_PLAYERS-1:0] dir_all;
   logic [NUM_PLAYERS-1:0]       chg_all;
   logic [NUM_PLAYERS-1:0]       drop_all;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(QDEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      logic [3:0]       raw;
      logic [3:0]       press;
      logic [DIR_W-1:0] cand;
      logic             cand_vld;
      logic [DIR_W-1:0] q_mem [QDEPTH];
      logic [PW-1:0]    rd_ptr;
      logic [PW-1:0]    wr_ptr;
      logic [PW-1:0]    tail_idx;
      logic [CW-1:0]    count;
      logic [DIR_W-1:0] dir_q;
      logic             chg_q;
      logic             drop_q;
      logic [DIR_W-1:0] ref_dir;
      logic             accept;
      logic             full;
      logic             pop;
      logic             push;
      logic             drop;

      assign raw = {bus.btn_d[p], bus.btn_u[p], bus.btn_r[p], bus.btn_l[p]};

      for (genvar b = 0; b < 4; b++) begin : g_btn
         dir_btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
         ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (raw[b]),
            .press(press[b])
         );
      end

      // One candidate per cycle: left > right > up > down
      always_comb begin
         cand     = '0;
         cand_vld = 1'b0;
         if (press[0]) begin
            cand     = DIR_LEFT;
            cand_vld = 1'b1;
         end else if (press[1]) begin
            cand     = DIR_RIGHT;
            cand_vld = 1'b1;
         end else if (press[2]) begin
            cand     = DIR_UP;
            cand_vld = 1'b1;
         end else if (press[3]) begin
            cand     = DIR_DOWN;
            cand_vld = 1'b1;
         end
      end

      // Turns are judged against the last queued heading so a chain of turns stays legal
      always_comb begin
         tail_idx = (wr_ptr == '0) ? PW'(QDEPTH - 1) : wr_ptr - 1'b1;
         ref_dir  = (count != '0) ? q_mem[tail_idx] : dir_q;
         accept   = cand_vld && dir_valid(cand) && (cand != ref_dir) &&
                    (cand != dir_opposite(ref_dir));
         full     = (count == CW'(QDEPTH));
         pop      = bus.tick && (count != '0);
         push     = accept && (!full || pop);
         drop     = accept && full && !pop;
      end

      // Queue storage; contents are don't-care while count says empty
      always_ff @(posedge clk) begin
         if (push) begin
            q_mem[wr_ptr] <= cand;
         end
      end

      // Queue pointers, heading register and the one-cycle status pulses
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dir_q  <= INIT_DIR;
            chg_q  <= 1'b0;
            drop_q <= 1'b0;
         end else begin
            chg_q  <= pop;
            drop_q <= drop;
            if (pop) begin
               dir_q  <= q_mem[rd_ptr];
               rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push) begin
               wr_ptr <= ptr_inc(wr_ptr);
            end
            if (push && !pop) begin
               count <= count + 1'b1;
            end else if (pop && !push) begin
               count <= count - 1'b1;
            end
         end
      end

      assign dir_all[DIR_W*p +: DIR_W] = dir_q;
      assign chg_all[p]                = chg_q;
      assign drop_all[p]               = drop_q;
   end

   assign bus.direction   = dir_all;
   assign bus.dir_changed = chg_all;
   assign bus.turn_drop   = drop_all;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - directed self-checking bench for snake_dir_ctrl (follows DIR_CTRL_DEBOUNCE_EN)
module tb_snake_dir_ctrl;

   localparam int NP  = 2;
   localparam int QD  = 2;
   localparam int DEB = 16;
`ifdef DIR_CTRL_DEBOUNCE_EN
   localparam int LAT    = DEB + 3;
   localparam bit DEB_EN = 1'b1;
`else
   localparam int LAT    = 3;
   localparam bit DEB_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   drop_cnt [NP];

   always #5 clk = ~clk;

   snake_dir_ctrl_if #(.NUM_PLAYERS(NP)) bus ();

   snake_dir_ctrl #(
      .NUM_PLAYERS(NP),
      .QDEPTH     (QD),
      .DEB_CYCLES (DEB),
      .INIT_DIR   (3'b010)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      for (int i = 0; i < NP; i++) drop_cnt[i] = 0;
   end

   always @(negedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (bus.turn_drop[i]) drop_cnt[i] = drop_cnt[i] + 1;
      end
   end

   task automatic set_pin(input int p, input int b, input logic v);
      case (b)
         0: bus.btn_l[p] = v;
         1: bus.btn_r[p] = v;
         2: bus.btn_u[p] = v;
         default: bus.btn_d[p] = v;
      endcase
   endtask

   task automatic press_btn(input int p, input int b);
      set_pin(p, b, 1'b1);
      repeat (LAT + 2) @(negedge clk);
      set_pin(p, b, 1'b0);
      repeat (LAT + 2) @(negedge clk);
   endtask

   task automatic do_tick();
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++; if (bus.direction !== 6'b010_010) begin bad++; $display("FAIL reset_dir got=%b exp=%b", bus.direction, 6'b010_010); end
      total++; if (bus.dir_changed !== 2'b00) begin bad++; $display("FAIL reset_chg got=%b exp=00", bus.dir_changed); end
      total++; if (bus.turn_drop !== 2'b00) begin bad++; $display("FAIL reset_drop got=%b exp=00", bus.turn_drop); end
      rst_n = 1'b1;
      @(negedge clk);
      press_btn(0, 2);
      press_btn(0, 0);
      do_tick();
      total++; if (bus.direction[2:0] !== 3'b011 || bus.dir_changed[0] !== 1'b1) begin bad++; $display("FAIL prereset_pop got=%b/%b exp=011/1", bus.direction[2:0], bus.dir_changed[0]); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (bus.direction !== 6'b010_010) begin bad++; $display("FAIL midreset_dir got=%b exp=%b", bus.direction, 6'b010_010); end
      total++; if (bus.dir_changed !== 2'b00) begin bad++; $display("FAIL midreset_chg got=%b exp=00", bus.dir_changed); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_tick();
      total++; if (bus.direction !== 6'b010_010 || bus.dir_changed !== 2'b00) begin bad++; $display("FAIL reset_flush got=%b/%b exp=010010/00", bus.direction, bus.dir_changed); end
   endtask

   task automatic test_turn_tick();
      set_pin(0, 2, 1'b1);
      repeat (LAT - 1) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      total++; if (bus.direction[2:0] !== 3'b010 || bus.dir_changed[0] !== 1'b0) begin bad++; $display("FAIL early_tick got=%b/%b exp=010/0", bus.direction[2:0], bus.dir_changed[0]); end
      @(negedge clk);
      bus.tick = 1'b0;
      total++; if (bus.direction[2:0] !== 3'b011) begin bad++; $display("FAIL turn_dir got=%b exp=011", bus.direction[2:0]); end
      total++; if (bus.dir_changed[0] !== 1'b1) begin bad++; $display("FAIL turn_chg got=%b exp=1", bus.dir_changed[0]); end
      @(negedge clk);
      total++; if (bus.dir_changed !== 2'b00) begin bad++; $display("FAIL turn_chg_width got=%b exp=00", bus.dir_changed); end
      total++; if (bus.direction[5:3] !== 3'b010) begin bad++; $display("FAIL turn_p1_indep got=%b exp=010", bus.direction[5:3]); end
      repeat (40 - LAT - 2) @(negedge clk);
      set_pin(0, 2, 1'b0);
      repeat (LAT + 2) @(negedge clk);
      do_tick();
      total++; if (bus.direction[2:0] !== 3'b011 || bus.dir_changed[0] !== 1'b0) begin bad++; $display("FAIL held_single got=%b/%b exp=011/0", bus.direction[2:0], bus.dir_changed[0]); end
   endtask

   task automatic test_reject();
      int d0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      d0 = drop_cnt[0];
      press_btn(0, 0);
      press_btn(0, 1);
      do_tick();
      total++; if (bus.direction !== 6'b010_010 || bus.dir_changed !== 2'b00) begin bad++; $display("FAIL reject got=%b/%b exp=010010/00", bus.direction, bus.dir_changed); end
      total++; if (drop_cnt[0] !== d0) begin bad++; $display("FAIL reject_drop got=%0d exp=%0d", drop_cnt[0], d0); end
   endtask

   task automatic test_fill_drop();
      int d0;
      d0 = drop_cnt[0];
      press_btn(0, 2);
      press_btn(0, 0);
      press_btn(0, 3);
      total++; if (drop_cnt[0] !== d0 + 1) begin bad++; $display("FAIL drop_pulse got=%0d exp=%0d", drop_cnt[0], d0 + 1); end
      do_tick();
      total++; if (bus.direction[2:0] !== 3'b011 || bus.dir_changed[0] !== 1'b1) begin bad++; $display("FAIL fill_tick1 got=%b/%b exp=011/1", bus.direction[2:0], bus.dir_changed[0]); end
      do_tick();
      total++; if (bus.direction[2:0] !== 3'b001 || bus.dir_changed[0] !== 1'b1) begin bad++; $display("FAIL fill_tick2 got=%b/%b exp=001/1", bus.direction[2:0], bus.dir_changed[0]); end
      do_tick();
      total++; if (bus.direction !== 6'b010_001 || bus.dir_changed !== 2'b00) begin bad++; $display("FAIL fill_tick3 got=%b/%b exp=010001/00", bus.direction, bus.dir_changed); end
   endtask

   task automatic test_simultaneous();
      set_pin(0, 2, 1'b1);
      set_pin(0, 3, 1'b1);
      repeat (LAT + 2) @(negedge clk);
      set_pin(0, 2, 1'b0);
      set_pin(0, 3, 1'b0);
      repeat (LAT + 2) @(negedge clk);
      do_tick();
      total++; if (bus.direction[2:0] !== 3'b011) begin bad++; $display("FAIL prio_ud got=%b exp=011", bus.direction[2:0]); end
      do_tick();
      total++; if (bus.dir_changed !== 2'b00) begin bad++; $display("FAIL prio_ud_single got=%b exp=00", bus.dir_changed); end
      press_btn(1, 2);
      do_tick();
      total++; if (bus.direction !== 6'b011_011 || bus.dir_changed !== 2'b10) begin bad++; $display("FAIL p1_up got=%b/%b exp=011011/10", bus.direction, bus.dir_changed); end
      set_pin(1, 0, 1'b1);
      set_pin(1, 2, 1'b1);
      repeat (LAT + 2) @(negedge clk);
      set_pin(1, 0, 1'b0);
      set_pin(1, 2, 1'b0);
      repeat (LAT + 2) @(negedge clk);
      do_tick();
      total++; if (bus.direction[5:3] !== 3'b001 || bus.dir_changed[1] !== 1'b1) begin bad++; $display("FAIL prio_lu got=%b/%b exp=001/1", bus.direction[5:3], bus.dir_changed[1]); end
      do_tick();
      total++; if (bus.direction !== 6'b001_011 || bus.dir_changed !== 2'b00) begin bad++; $display("FAIL prio_lu_single got=%b/%b exp=001011/00", bus.direction, bus.dir_changed); end
   endtask

   task automatic test_push_pop_full();
      int d0;
      press_btn(0, 0);
      press_btn(0, 2);
      d0 = drop_cnt[0];
      set_pin(0, 1, 1'b1);
      repeat (LAT - 1) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      total++; if (bus.direction[2:0] !== 3'b001 || bus.dir_changed[0] !== 1'b1) begin bad++; $display("FAIL pushpop_head got=%b/%b exp=001/1", bus.direction[2:0], bus.dir_changed[0]); end
      repeat (3) @(negedge clk);
      set_pin(0, 1, 1'b0);
      repeat (LAT + 2) @(negedge clk);
      total++; if (drop_cnt[0] !== d0) begin bad++; $display("FAIL pushpop_nodrop got=%0d exp=%0d", drop_cnt[0], d0); end
      do_tick();
      total++; if (bus.direction[2:0] !== 3'b011) begin bad++; $display("FAIL pushpop_t1 got=%b exp=011", bus.direction[2:0]); end
      do_tick();
      total++; if (bus.direction[2:0] !== 3'b010 || bus.dir_changed[0] !== 1'b1) begin bad++; $display("FAIL pushpop_t2 got=%b/%b exp=010/1", bus.direction[2:0], bus.dir_changed[0]); end
      do_tick();
      total++; if (bus.direction !== 6'b001_010 || bus.dir_changed !== 2'b00) begin bad++; $display("FAIL pushpop_t3 got=%b/%b exp=001010/00", bus.direction, bus.dir_changed); end
   endtask

   task automatic test_bounce();
      int d0;
      int d1;
      logic [2:0] exp_p1;
      d0 = drop_cnt[0];
      d1 = drop_cnt[1];
      exp_p1 = DEB_EN ? 3'b001 : 3'b100;
      for (int k = 0; k < 5; k++) begin
         set_pin(1, 3, 1'b1);
         repeat (3) @(negedge clk);
         set_pin(1, 3, 1'b0);
         repeat (3) @(negedge clk);
      end
      repeat (LAT + 2) @(negedge clk);
      do_tick();
      total++; if (bus.direction[5:3] !== exp_p1 || bus.dir_changed[1] !== !DEB_EN) begin bad++; $display("FAIL bounce_p1 got=%b/%b exp=%b/%b", bus.direction[5:3], bus.dir_changed[1], exp_p1, !DEB_EN); end
      total++; if (bus.direction[2:0] !== 3'b010 || bus.dir_changed[0] !== 1'b0) begin bad++; $display("FAIL bounce_p0 got=%b/%b exp=010/0", bus.direction[2:0], bus.dir_changed[0]); end
      do_tick();
      total++; if (bus.direction[5:3] !== exp_p1 || bus.dir_changed !== 2'b00) begin bad++; $display("FAIL bounce_single got=%b/%b exp=%b/00", bus.direction[5:3], bus.dir_changed, exp_p1); end
      total++; if (drop_cnt[0] !== d0 || drop_cnt[1] !== d1) begin bad++; $display("FAIL bounce_drop got=%0d,%0d exp=%0d,%0d", drop_cnt[0], drop_cnt[1], d0, d1); end
   endtask

   initial begin
      bus.btn_l = '0;
      bus.btn_r = '0;
      bus.btn_u = '0;
      bus.btn_d = '0;
      bus.tick  = 1'b0;
      test_reset();
      test_turn_tick();
      test_reject();
      test_fill_drop();
      test_simultaneous();
      test_push_pop_full();
      test_bounce();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
